// File: rtl/if_stage_buf.sv
// Instruction-fetch stage with a bus request engine, an in-flight pc queue and a {pc, inst} buffer feeding ID.
// Optional macro IF_ADEL_EN adds fs_to_ds_adel and turns misaligned fetch pcs into address-error entries.
module if_stage_buf #(
  parameter logic [31:0] RESET_PC        = 32'hbfc00000,
  parameter logic [31:0] EX_VECTOR       = 32'hbfc00380,
  parameter int          FIFO_DEPTH      = 4,
  parameter int          MAX_OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ds_allowin,
  input  logic        br_stall,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic        ws_ex,
  output logic        fs_to_ds_valid,
  output logic [31:0] fs_to_ds_inst,
  output logic [31:0] fs_to_ds_pc,
`ifdef IF_ADEL_EN
  output logic        fs_to_ds_adel,
`endif
  output logic        inst_req,
  output logic [31:0] inst_addr,
  input  logic        inst_addr_ok,
  input  logic        inst_data_ok,
  input  logic [31:0] inst_rdata
);

  localparam int FW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);
  localparam int QW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int SW = $clog2(FIFO_DEPTH + MAX_OUTSTANDING + 1);

  logic [31:0]   pc_reg;
  logic [OW-1:0] out_cnt_reg;
  logic [OW-1:0] cancel_reg;

  logic [31:0]   fifo_pc   [FIFO_DEPTH];
  logic [31:0]   fifo_inst [FIFO_DEPTH];
  logic [FW-1:0] head_reg;
  logic [FW-1:0] tail_reg;
  logic [CW-1:0] count_reg;

  // pcs of requests whose responses will still be kept (cancelled ones are not tracked)
  logic [31:0]   pcq_pc [MAX_OUTSTANDING];
  logic [QW-1:0] pcq_head_reg;
  logic [QW-1:0] pcq_tail_reg;

  logic          redirect;
  logic [SW-1:0] occupancy;
  logic          has_space;
  logic          below_max;
  logic          fetch_ok;
  logic          adel_push;
  logic          accept;
  logic          resp_live;
  logic          resp_push;
  logic          push;
  logic          pop;
  logic [31:0]   push_pc;
  logic [31:0]   push_inst;

  function automatic logic [QW-1:0] q_inc(input logic [QW-1:0] p);
    return (p == QW'(MAX_OUTSTANDING - 1)) ? '0 : p + QW'(1);
  endfunction

  assign redirect  = ws_ex | br_taken;
  // cancelled requests still hold a slot reservation until their response returns
  assign occupancy = SW'(count_reg) + SW'(out_cnt_reg);
  assign has_space = occupancy < SW'(FIFO_DEPTH);
  assign below_max = out_cnt_reg < OW'(MAX_OUTSTANDING);

`ifdef IF_ADEL_EN
  logic fifo_adel [FIFO_DEPTH];
  logic adel_stall_reg;
  logic misaligned;

  assign misaligned = pc_reg[1:0] != 2'b00;
  assign fetch_ok   = !misaligned && !adel_stall_reg;
  assign adel_push  = !reset && !br_stall && !redirect && !adel_stall_reg && misaligned &&
                      has_space && (out_cnt_reg == cancel_reg);
  assign fs_to_ds_adel = fifo_adel[head_reg];

  always_ff @(posedge clk) begin
    if (reset || redirect)
      adel_stall_reg <= 1'b0;
    else if (adel_push)
      adel_stall_reg <= 1'b1;
  end

  always_ff @(posedge clk) begin
    if (push)
      fifo_adel[tail_reg] <= adel_push;
  end
`else
  assign fetch_ok  = 1'b1;
  assign adel_push = 1'b0;
`endif

  assign inst_req  = !reset && !br_stall && !redirect && below_max && has_space && fetch_ok;
  assign inst_addr = pc_reg;
  assign accept    = inst_req && inst_addr_ok;

  assign resp_live = inst_data_ok && (cancel_reg == '0);
  assign resp_push = resp_live && !redirect;
  assign push      = resp_push || adel_push;
  assign pop       = fs_to_ds_valid && ds_allowin;
  assign push_pc   = adel_push ? pc_reg : pcq_pc[pcq_head_reg];
  assign push_inst = adel_push ? 32'h0 : inst_rdata;

  assign fs_to_ds_valid = !reset && !redirect && (count_reg != '0);
  assign fs_to_ds_pc    = fifo_pc[head_reg];
  assign fs_to_ds_inst  = fifo_inst[head_reg];

  always_ff @(posedge clk) begin
    if (reset)
      pc_reg <= RESET_PC;
    else if (redirect)
      pc_reg <= ws_ex ? EX_VECTOR : br_target;
    else if (accept)
      pc_reg <= pc_reg + 32'd4;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_cnt_reg <= '0;
      cancel_reg  <= '0;
    end else begin
      out_cnt_reg <= out_cnt_reg + OW'(accept) - OW'(inst_data_ok);
      // on redirect every request still in flight after this cycle becomes a discard
      if (redirect)
        cancel_reg <= out_cnt_reg - OW'(inst_data_ok);
      else if (inst_data_ok && cancel_reg != '0)
        cancel_reg <= cancel_reg - OW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset || redirect) begin
      pcq_head_reg <= '0;
      pcq_tail_reg <= '0;
    end else begin
      if (accept)
        pcq_tail_reg <= q_inc(pcq_tail_reg);
      if (resp_live)
        pcq_head_reg <= q_inc(pcq_head_reg);
    end
  end

  always_ff @(posedge clk) begin
    if (accept)
      pcq_pc[pcq_tail_reg] <= pc_reg;
  end

  always_ff @(posedge clk) begin
    if (reset || redirect) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
    end else begin
      if (push)
        tail_reg <= tail_reg + FW'(1);
      if (pop)
        head_reg <= head_reg + FW'(1);
      count_reg <= count_reg + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_pc[tail_reg]   <= push_pc;
      fifo_inst[tail_reg] <= push_inst;
    end
  end

endmodule

// File: tb/tb_if_stage_buf.sv
// Bench for if_stage_buf: queue-level reference model, directed scenarios, then randomized traffic.
// Build with IF_ADEL_EN defined to also exercise the address-error entry.
module tb_if_stage_buf;

  localparam logic [31:0] RESET_PC  = 32'hbfc00000;
  localparam logic [31:0] EX_VECTOR = 32'hbfc00380;
  localparam int DEPTH = 4;
  localparam int MAXO  = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ds_allowin = 1'b0, br_stall = 1'b0, br_taken = 1'b0, ws_ex = 1'b0;
  logic [31:0] br_target = 32'h0;
  logic        fs_to_ds_valid;
  logic [31:0] fs_to_ds_inst, fs_to_ds_pc;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok = 1'b0, inst_data_ok = 1'b0;
  logic [31:0] inst_rdata = 32'h0;
`ifdef IF_ADEL_EN
  logic        fs_to_ds_adel;
`endif

  always #5 clk = ~clk;

  if_stage_buf #(
    .RESET_PC(RESET_PC), .EX_VECTOR(EX_VECTOR), .FIFO_DEPTH(DEPTH), .MAX_OUTSTANDING(MAXO)
  ) dut (
    .clk(clk), .reset(reset), .ds_allowin(ds_allowin), .br_stall(br_stall),
    .br_taken(br_taken), .br_target(br_target), .ws_ex(ws_ex),
    .fs_to_ds_valid(fs_to_ds_valid), .fs_to_ds_inst(fs_to_ds_inst), .fs_to_ds_pc(fs_to_ds_pc),
`ifdef IF_ADEL_EN
    .fs_to_ds_adel(fs_to_ds_adel),
`endif
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata)
  );

  typedef struct { logic [31:0] pc; logic cancelled; } flight_t;
  typedef struct { logic [31:0] pc; logic [31:0] inst; logic adel; } entry_t;

  flight_t     m_fl[$];
  entry_t      m_fifo[$];
  logic [31:0] m_pc;
  logic        m_stalled;

  logic [31:0] id_log[$];
  logic        adel_log[$];
  logic [31:0] acc_log[$];
  logic        last_valid, last_req;
  logic        verbose = 1'b1;

  int n_checks = 0;
  int n_pass   = 0;

  logic        d_allowin, d_stall, d_brt, d_ex, d_aok, d_dok;
  logic [31:0] d_target;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h1234abcd;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  task automatic set_in(input logic allowin, input logic stall, input logic brt,
                        input logic [31:0] target, input logic ex, input logic aok, input logic dok);
    d_allowin = allowin; d_stall = stall; d_brt = brt; d_target = target;
    d_ex = ex; d_aok = aok; d_dok = dok;
  endtask

  // one clock: drive inputs, compare against the model at the falling edge, advance the model
  task automatic step();
    logic    redir, space, mis, exp_req, exp_valid, adel_push;
    flight_t r;
    ds_allowin   = d_allowin;
    br_stall     = d_stall;
    br_taken     = d_brt;
    br_target    = d_target;
    ws_ex        = d_ex;
    inst_addr_ok = d_aok;
    inst_data_ok = d_dok && (m_fl.size() != 0);
    inst_rdata   = inst_data_ok ? mem(m_fl[0].pc) : $urandom;
    @(negedge clk);
    redir = d_ex || d_brt;
    space = (m_fifo.size() + m_fl.size()) < DEPTH;
`ifdef IF_ADEL_EN
    mis = m_pc[1:0] != 2'b00;
`else
    mis = 1'b0;
`endif
    exp_req   = !redir && !d_stall && (m_fl.size() < MAXO) && space && !mis && !m_stalled;
    adel_push = !redir && !d_stall && space && mis && !m_stalled;
    exp_valid = (m_fifo.size() != 0) && !redir;

    check("inst_req", 32'(inst_req), 32'(exp_req));
    check("inst_addr", inst_addr, m_pc);
    check("fs_to_ds_valid", 32'(fs_to_ds_valid), 32'(exp_valid));
    if (exp_valid) begin
      check("fs_to_ds_pc", fs_to_ds_pc, m_fifo[0].pc);
      check("fs_to_ds_inst", fs_to_ds_inst, m_fifo[0].inst);
`ifdef IF_ADEL_EN
      check("fs_to_ds_adel", 32'(fs_to_ds_adel), 32'(m_fifo[0].adel));
`endif
    end
    last_valid = fs_to_ds_valid;
    last_req   = inst_req;
    if (inst_req && inst_addr_ok) acc_log.push_back(inst_addr);
    if (fs_to_ds_valid && ds_allowin) begin
      id_log.push_back(fs_to_ds_pc);
`ifdef IF_ADEL_EN
      adel_log.push_back(fs_to_ds_adel);
`else
      adel_log.push_back(1'b0);
`endif
      if (verbose) $display("id  pc=%h inst=%h", fs_to_ds_pc, fs_to_ds_inst);
    end

    if (exp_valid && d_allowin) void'(m_fifo.pop_front());
    if (inst_data_ok) begin
      r = m_fl.pop_front();
      if (!r.cancelled && !redir) m_fifo.push_back('{r.pc, inst_rdata, 1'b0});
    end
    if (redir) begin
      m_fifo.delete();
      foreach (m_fl[i]) m_fl[i].cancelled = 1'b1;
      m_pc = d_ex ? EX_VECTOR : d_target;
      m_stalled = 1'b0;
    end else if (exp_req && d_aok) begin
      m_fl.push_back('{m_pc, 1'b0});
      m_pc = m_pc + 32'd4;
    end else if (adel_push) begin
      m_fifo.push_back('{m_pc, 32'h0, 1'b1});
      m_stalled = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    int mark_id, mark_acc;
    logic [31:0] tgt;

    repeat (3) begin
      @(negedge clk);
      check("reset inst_req", 32'(inst_req), 32'h0);
      check("reset fs_to_ds_valid", 32'(fs_to_ds_valid), 32'h0);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    m_pc = RESET_PC;
    m_stalled = 1'b0;

    // straight-line fetch, one response per cycle
    set_in(1, 0, 0, 0, 0, 1, 1);
    run(6);
    check("first acc", acc_log[0], 32'hbfc00000);
    check("second acc", acc_log[1], 32'hbfc00004);
    check("third acc", acc_log[2], 32'hbfc00008);
    check("first id pc", id_log[0], 32'hbfc00000);
    check("second id pc", id_log[1], 32'hbfc00004);
    check("third id pc", id_log[2], 32'hbfc00008);

    // ID stalled: buffer plus in-flight fills to DEPTH, then issue stops
    set_in(0, 0, 0, 0, 0, 1, 1);
    run(8);
    check("full req dropped", 32'(last_req), 32'h0);
    check("full head valid", 32'(last_valid), 32'h1);
    set_in(1, 0, 0, 0, 0, 0, 1);
    run(8);

    // branch with two in flight, one response arriving in the redirect cycle
    set_in(1, 0, 0, 0, 0, 1, 0);
    run(2);
    mark_id  = id_log.size();
    mark_acc = acc_log.size();
    set_in(1, 0, 1, 32'hbfc00100, 0, 1, 1);
    step();
    set_in(1, 0, 0, 0, 0, 1, 1);
    step();
    check("post-branch valid", 32'(last_valid), 32'h0);
    run(5);
    check("branch acc", acc_log[mark_acc], 32'hbfc00100);
    check("branch id pc", id_log[mark_id], 32'hbfc00100);

    // exception and branch together
    set_in(0, 0, 0, 0, 0, 1, 1);
    run(3);
    set_in(1, 0, 1, 32'hbfc00200, 1, 0, 1);
    step();
    check("ex cycle valid", 32'(last_valid), 32'h0);
    mark_acc = acc_log.size();
    set_in(1, 0, 0, 0, 0, 1, 1);
    run(4);
    check("ex vector acc", acc_log[mark_acc], 32'hbfc00380);

    // br_stall with one request outstanding
    set_in(1, 0, 0, 0, 0, 0, 1);
    run(6);
    set_in(1, 0, 0, 0, 0, 1, 0);
    step();
    mark_id  = id_log.size();
    mark_acc = acc_log.size();
    set_in(1, 1, 0, 0, 0, 1, 0); step();
    set_in(1, 1, 0, 0, 0, 1, 1); step();
    set_in(1, 1, 0, 0, 0, 1, 0); step();
    check("stall accepts", 32'(acc_log.size() - mark_acc), 32'h0);
    check("stall delivered", 32'(id_log.size() - mark_id), 32'h1);
    set_in(1, 0, 0, 0, 0, 1, 1);
    run(4);

`ifdef IF_ADEL_EN
    set_in(1, 0, 0, 0, 0, 0, 1);
    run(6);
    set_in(1, 0, 1, 32'hbfc00102, 0, 1, 1);
    step();
    mark_acc = acc_log.size();
    set_in(1, 0, 0, 0, 0, 1, 1);
    run(6);
    check("adel no request", 32'(acc_log.size() - mark_acc), 32'h0);
    check("adel pc", id_log[id_log.size() - 1], 32'hbfc00102);
    check("adel flag", 32'(adel_log[adel_log.size() - 1]), 32'h1);
    set_in(1, 0, 0, 0, 1, 1, 1);
    step();
    mark_acc = acc_log.size();
    set_in(1, 0, 0, 0, 0, 1, 1);
    run(3);
    check("adel recover", acc_log[mark_acc], 32'hbfc00380);
`endif

    // randomized traffic
    verbose = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      tgt = {$urandom} & 32'hfffffffc;
`ifdef IF_ADEL_EN
      if ($urandom_range(0, 3) == 0) tgt[1:0] = 2'($urandom_range(1, 3));
`endif
      set_in($urandom_range(0, 3) != 0, $urandom_range(0, 9) == 0,
             $urandom_range(0, 19) == 0, tgt, $urandom_range(0, 49) == 0,
             $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 6);
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
